// File: rtl/image_streamer_if.sv
// Frame-in / pixel-out bundle for image_streamer.
// The master side supplies a flat frame and consumes the pixel stream;
// the slave side is the streamer itself.
interface image_streamer_if #(
  parameter int IMAGE_BITS = 8,
  parameter int MATRIX_N   = 120,
  parameter int MATRIX_M   = 120
);
  localparam int FLAT_WIDE = IMAGE_BITS * MATRIX_N * MATRIX_M;

  logic                  ReqIn;
  logic [FLAT_WIDE-1:0]  ImgMat;
  logic                  AckIn;
  logic [IMAGE_BITS-1:0] PixelOut;
  logic                  PixelValid;
  logic                  PixelReady;
  logic                  LineEnd;
  logic                  FrameEnd;
  logic                  Busy;

  modport master (
    output ReqIn, ImgMat, PixelReady,
    input  AckIn, PixelOut, PixelValid, LineEnd, FrameEnd, Busy
  );

  modport slave (
    input  ReqIn, ImgMat, PixelReady,
    output AckIn, PixelOut, PixelValid, LineEnd, FrameEnd, Busy
  );
endinterface

// File: rtl/image_streamer.sv
// Captures a whole image matrix on a Req/Ack handshake and replays it
// in raster order as a valid/ready pixel stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no frame held; waiting for ReqIn to capture ImgMat
// S_STREAM | frame buffered; presenting pixel (row, col) until accepted
module image_streamer #(
  parameter int IMAGE_BITS = 8,
  parameter int MATRIX_N   = 120,
  parameter int MATRIX_M   = 120
) (
  input logic             Clk,
  input logic             Reset,
  image_streamer_if.slave bus
);
  localparam int FLAT_WIDE = IMAGE_BITS * MATRIX_N * MATRIX_M;
  localparam int CW = (MATRIX_N > 1) ? $clog2(MATRIX_N) : 1;
  localparam int RW = (MATRIX_M > 1) ? $clog2(MATRIX_M) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_M - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 ack_q, ack_d;
  logic                 load;
  logic [FLAT_WIDE-1:0] buf_q;
  logic                 col_at_last;
  logic                 row_at_last;
  logic                 streaming;
  logic [31:0]          pix_idx;

  assign streaming   = (state_q == S_STREAM);
  assign col_at_last = (col_q == COL_LAST);
  assign row_at_last = (row_q == ROW_LAST);

  // Next-state logic: capture in IDLE, raster walk on each accepted beat
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ack_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ReqIn) begin
          load    = 1'b1;
          ack_d   = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // PixelValid is always high here, so ready alone means accept
        if (bus.PixelReady) begin
          if (col_at_last) begin
            col_d = '0;
            if (row_at_last) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset discards any partial frame
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ack_q   <= ack_d;
    end
  end

  // Frame buffer: ImgMat only matters on the capture edge
  always_ff @(posedge Clk) begin
    if (load && !Reset) begin
      buf_q <= bus.ImgMat;
    end
  end

  assign pix_idx = 32'(row_q) * 32'(MATRIX_N) + 32'(col_q);

  // Pixel output is gated so it reads zero whenever nothing is presented
  always_comb begin
    bus.PixelOut = '0;
    if (streaming) begin
      bus.PixelOut = buf_q[pix_idx*IMAGE_BITS +: IMAGE_BITS];
    end
  end

  assign bus.AckIn      = ack_q;
  assign bus.PixelValid = streaming;
  assign bus.Busy       = streaming;
  assign bus.LineEnd    = streaming & col_at_last;
  assign bus.FrameEnd   = streaming & col_at_last & row_at_last;
endmodule

// File: tb/tb_image_streamer.sv
// Scoreboard bench for image_streamer: a 4x3 instance for the main
// scenarios and a 1x1 instance for the single-pixel corner.
module tb_image_streamer;
  localparam int IB   = 8;
  localparam int N    = 4;
  localparam int M    = 3;
  localparam int NPIX = N * M;

  typedef struct packed {
    logic [IB-1:0] px;
    logic          le;
    logic          fe;
  } beat_t;

  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   fe_cyc = -1;
  beat_t exp_q[$];
  int    ack_cyc[$];
  int    idle_cyc[$];

  image_streamer_if #(.IMAGE_BITS(IB), .MATRIX_N(N), .MATRIX_M(M)) u_if ();
  image_streamer_if #(.IMAGE_BITS(IB), .MATRIX_N(1), .MATRIX_M(1)) u_if1 ();

  image_streamer #(.IMAGE_BITS(IB), .MATRIX_N(N), .MATRIX_M(M)) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (u_if.slave)
  );

  image_streamer #(.IMAGE_BITS(IB), .MATRIX_N(1), .MATRIX_M(1)) u_dut1 (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (u_if1.slave)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic set_frame(input logic [IB-1:0] base);
    for (int k = 0; k < NPIX; k++) u_if.ImgMat[IB*k +: IB] = base + IB'(k);
  endtask

  task automatic push_frame(input logic [IB-1:0] base, input int count);
    beat_t b;
    for (int k = 0; k < count; k++) begin
      b.px = base + IB'(k);
      b.le = ((k % N) == N - 1);
      b.fe = (k == NPIX - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (u_if.Busy !== 1'b0 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({name, "_idle_reached"}, 32'(n < 100), 32'd1);
  endtask

  task automatic wait_acks(input string name, input int want);
    int n = 0;
    while (ack_cyc.size() < want && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({name, "_ack_seen"}, 32'(n < 100), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks stall hold
  initial begin
    beat_t got, held, e;
    logic  stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge Clk);
      if (u_if.AckIn === 1'b1) ack_cyc.push_back(cyc);
      if (u_if.PixelValid !== 1'b1) idle_cyc.push_back(cyc);
      got = {u_if.PixelOut, u_if.LineEnd, u_if.FrameEnd};
      if (stalled && u_if.PixelValid === 1'b1) begin
        n_cmp++;
        if (got !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got px=%h le=%b fe=%b required px=%h le=%b fe=%b",
                   got.px, got.le, got.fe, held.px, held.le, held.fe);
        end
      end
      if (u_if.PixelValid === 1'b1 && u_if.PixelReady === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got px=%h le=%b fe=%b required no beat",
                   got.px, got.le, got.fe);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL beat: got px=%h le=%b fe=%b required px=%h le=%b fe=%b",
                     got.px, got.le, got.fe, e.px, e.le, e.fe);
          end
        end
        if (got.fe === 1'b1) fe_cyc = cyc;
      end
      stalled = (u_if.PixelValid === 1'b1) && (u_if.PixelReady !== 1'b1) && (Reset !== 1'b1);
      held    = got;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    Reset            = 1'b1;
    u_if.ReqIn       = 1'b0;
    u_if.ImgMat      = '0;
    u_if.PixelReady  = 1'b0;
    u_if1.ReqIn      = 1'b0;
    u_if1.ImgMat     = '0;
    u_if1.PixelReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ack",   32'(u_if.AckIn),      0);
    chk("rst_valid", 32'(u_if.PixelValid), 0);
    chk("rst_pixel", 32'(u_if.PixelOut),   0);
    chk("rst_ends",  32'({u_if.LineEnd, u_if.FrameEnd}), 0);
    chk("rst_busy",  32'(u_if.Busy),       0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // 1: single-cycle request, ready held high
    set_frame(8'd1);
    push_frame(8'd1, NPIX);
    ack_cyc.delete();
    u_if.PixelReady = 1'b1;
    u_if.ReqIn      = 1'b1;
    @(posedge Clk); #1;
    u_if.ReqIn = 1'b0;
    chk("t1_ack_pulse", 32'(u_if.AckIn), 1);
    chk("t1_first_px",  32'(u_if.PixelOut), 1);
    wait_idle("t1");
    chk("t1_valid_after", 32'(u_if.PixelValid), 0);
    chk("t1_ack_count",   ack_cyc.size(), 1);
    chk("t1_last_accept", fe_cyc - ((ack_cyc.size() > 0) ? ack_cyc[0] : 0), 11);
    chk("t1_sb_empty",    exp_q.size(), 0);

    // 2: ready toggling 1,0,1,0...
    push_frame(8'd1, NPIX);
    ack_cyc.delete();
    u_if.ReqIn = 1'b1;
    @(posedge Clk); #1;
    u_if.ReqIn = 1'b0;
    begin
      int n = 0;
      while (u_if.Busy === 1'b1 && n < 100) begin
        @(posedge Clk); #1;
        u_if.PixelReady = ~u_if.PixelReady;
        n++;
      end
      chk("t2_idle_reached", 32'(n < 100), 1);
    end
    u_if.PixelReady = 1'b1;
    chk("t2_last_accept", fe_cyc - ((ack_cyc.size() > 0) ? ack_cyc[0] : 0), 22);
    chk("t2_sb_empty",    exp_q.size(), 0);

    // 3: ImgMat trashed right after capture
    push_frame(8'd1, NPIX);
    u_if.ReqIn = 1'b1;
    @(posedge Clk); #1;
    u_if.ReqIn  = 1'b0;
    u_if.ImgMat = '1;
    wait_idle("t3");
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: ReqIn held high across two alternating frames
    set_frame(8'd1);
    push_frame(8'd1, NPIX);
    push_frame(8'h41, NPIX);
    ack_cyc.delete();
    idle_cyc.delete();
    u_if.ReqIn = 1'b1;
    wait_acks("t4a", 1);
    set_frame(8'h41);
    wait_acks("t4b", 2);
    u_if.ReqIn = 1'b0;
    wait_idle("t4");
    chk("t4_ack_count", ack_cyc.size(), 2);
    if (ack_cyc.size() >= 2) begin
      int gaps = 0;
      int gap_at = -1;
      chk("t4_ack_spacing", ack_cyc[1] - ack_cyc[0], 13);
      foreach (idle_cyc[i]) begin
        if (idle_cyc[i] > ack_cyc[0] && idle_cyc[i] < ack_cyc[1]) begin
          gaps++;
          gap_at = idle_cyc[i];
        end
      end
      chk("t4_gap_count", gaps, 1);
      chk("t4_gap_cycle", gap_at, ack_cyc[1] - 1);
    end
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: reset after five accepted beats, with ReqIn high during reset
    set_frame(8'd1);
    push_frame(8'd1, 5);
    ack_cyc.delete();
    u_if.ReqIn = 1'b1;
    @(posedge Clk); #1;
    u_if.ReqIn = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    u_if.PixelReady = 1'b0;
    u_if.ReqIn      = 1'b1;
    Reset           = 1'b1;
    @(posedge Clk); #1;
    chk("t5_ack",   32'(u_if.AckIn),      0);
    chk("t5_valid", 32'(u_if.PixelValid), 0);
    chk("t5_pixel", 32'(u_if.PixelOut),   0);
    chk("t5_ends",  32'({u_if.LineEnd, u_if.FrameEnd}), 0);
    chk("t5_busy",  32'(u_if.Busy),       0);
    chk("t5_sb_partial", exp_q.size(), 0);
    chk("t5_ack_count_reset", ack_cyc.size(), 1);
    Reset           = 1'b0;
    u_if.PixelReady = 1'b1;
    push_frame(8'd1, NPIX);
    @(posedge Clk); #1;
    u_if.ReqIn = 1'b0;
    chk("t5_restart_ack", 32'(u_if.AckIn), 1);
    chk("t5_restart_px",  32'(u_if.PixelOut), 1);
    wait_idle("t5");
    chk("t5_ack_count", ack_cyc.size(), 2);
    chk("t5_sb_empty",  exp_q.size(), 0);

    // 6: 1x1 matrix
    u_if1.ImgMat     = 8'hA5;
    u_if1.PixelReady = 1'b1;
    u_if1.ReqIn      = 1'b1;
    @(posedge Clk); #1;
    u_if1.ReqIn = 1'b0;
    chk("t6_ack",   32'(u_if1.AckIn),      1);
    chk("t6_valid", 32'(u_if1.PixelValid), 1);
    chk("t6_pixel", 32'(u_if1.PixelOut),   32'hA5);
    chk("t6_ends",  32'({u_if1.LineEnd, u_if1.FrameEnd}), 32'h3);
    @(posedge Clk); #1;
    chk("t6_valid_after", 32'(u_if1.PixelValid), 0);
    chk("t6_busy_after",  32'(u_if1.Busy),       0);
    chk("t6_ack_after",   32'(u_if1.AckIn),      0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/image_streamer.md
# image_streamer

Pipeline sink that accepts a full image matrix from the preceding matrix stage over the Req/Ack handshake and replays it as a raster-order pixel stream, one pixel per accepted beat, under valid/ready flow control. It sits at the output end of the Hough pipeline, for example feeding a display or debug UART path. It is the inverse of the camera-side stage, which packs camera data into a matrix.

## Interface
- IMAGE_BITS, 8, bits per pixel
- MATRIX_N, 120, pixels across (columns)
- MATRIX_M, 120, pixels down (rows)
- FLAT_WIDE, IMAGE_BITS*MATRIX_N*MATRIX_M, derived; do not override
- Clk  in  1  sole clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- ReqIn  in  1  upstream asserts while ImgMat holds a valid frame
- ImgMat  in  FLAT_WIDE  flat image; pixel k = row*MATRIX_N+col at bits [IMAGE_BITS*k +: IMAGE_BITS]
- AckIn  out  1  registered one-cycle pulse: frame captured
- PixelOut  out  IMAGE_BITS  current pixel
- PixelValid  out  1  PixelOut is valid
- PixelReady  in  1  downstream accepts the pixel this cycle
- LineEnd  out  1  qualifies PixelOut as last pixel of a row (col = MATRIX_N-1)
- FrameEnd  out  1  qualifies PixelOut as last pixel of the frame
- Busy  out  1  high while a frame is held, STREAM state

## Operation
- Two states: IDLE and STREAM. Reset enters IDLE.
- IDLE: if ReqIn=1 at a clock edge, latch ImgMat into an internal frame buffer, clear the row and column counters, and enter STREAM. AckIn=1 for exactly the following cycle.
- ImgMat is sampled only on that capture edge. Later changes on ImgMat have no effect on the frame being streamed.
- STREAM: PixelOut = buffer pixel at (row, col). PixelValid=1.
- A beat is accepted on an edge with PixelValid & PixelReady.
- On accept, col increments. When col = MATRIX_N-1, col wraps to 0 and row increments.
- When the accepted pixel is (MATRIX_M-1, MATRIX_N-1), return to IDLE.
- LineEnd = PixelValid & (col = MATRIX_N-1).
- FrameEnd = PixelValid & (row = MATRIX_M-1) & (col = MATRIX_N-1).
- If PixelReady=0, PixelOut, LineEnd and FrameEnd hold stable while PixelValid=1. PixelValid never drops before the beat is accepted.
- ReqIn is ignored in STREAM. AckIn is never issued mid-frame.
- Upstream may keep ReqIn high after AckIn; that is treated as the next frame and is captured at the next IDLE edge.
- Counter widths are $clog2(MATRIX_N) and $clog2(MATRIX_M), minimum 1 bit. No counter ever reaches MATRIX_N or MATRIX_M.
- Reset mid-frame: the partial frame is discarded, no FrameEnd is produced, and no AckIn is produced.

## Timing
- Reset values: AckIn=0, PixelValid=0, PixelOut=0, LineEnd=0, FrameEnd=0, Busy=0. Counters are 0 and state is IDLE.
- Capture at edge t:
  - cycle t+1: AckIn=1, Busy=1, PixelValid=1, PixelOut=pixel 0.
  - cycle t+2: AckIn=0.
- With PixelReady held at 1:
  - pixel k is presented in cycle t+1+k;
  - the last accept is at edge t+MATRIX_N*MATRIX_M;
  - the cycle after that has PixelValid=0 and Busy=0.
- Back-to-back frames with ReqIn held high: the next capture is one edge after the return to IDLE. Minimum frame period is MATRIX_N*MATRIX_M+1 cycles.
- Reset and ReqIn high in the same cycle: reset wins and no capture occurs.
- Reset has priority over all other events.
- PixelReady may toggle every cycle. Throughput is one pixel per cycle while PixelReady=1.

## Test plan
All scenarios use IMAGE_BITS=8, MATRIX_N=4, MATRIX_M=3 unless noted.
1. Pixel k = k+1. Pulse ReqIn for 1 cycle with PixelReady=1 -> AckIn pulses once. Twelve beats 1..12 follow on consecutive cycles. LineEnd is set on values 4, 8 and 12. FrameEnd is set on 12 only. Then PixelValid=0 and Busy=0.
2. PixelReady toggles 1,0,1,0… -> output sequence is unchanged (1..12). PixelOut is stable across every stall cycle. 23 cycles elapse from the first valid to the last accept.
3. ImgMat is changed to all 0xFF one cycle after capture -> the stream is still 1..12.
4. ReqIn held high with two alternating frames -> AckIn pulses 13 cycles apart. The two frames stream back to back with one PixelValid=0 gap cycle between them.
5. Reset is asserted after 5 accepted beats -> next cycle all outputs are 0. A new ReqIn restarts the stream at pixel value 1 with a fresh AckIn.
6. MATRIX_N=1, MATRIX_M=1, pixel 0xA5 -> a single beat with PixelOut=0xA5 and LineEnd=FrameEnd=1, then return to IDLE.
